// File: rtl/conv2_pkg.sv
// conv2 shared types and sizes.
// Second convolution stage of the LeNet-style pipeline.
package conv2_pkg;
  localparam int IN_SIZE_D    = 10;
  localparam int OUT_SIZE_D   = 8;
  localparam int CHANNEL_D    = 6;
  localparam int IN_ADDR_W_D  = 11;
  localparam int OUT_ADDR_W_D = 6;
  localparam int W_ADDR_W_D   = 6;
  localparam int NUM_W_D      = 16;
  localparam int ACC_W_D      = 40;
  localparam int Q_FRAC       = 8;
  localparam int KSIZE        = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;
endpackage

// File: rtl/conv2_with_memory_control_mac.sv
// conv2 multiply-accumulate datapath and output stage.
// Bias add, Q8.8 rescale, saturation and optional ReLU.
module conv2_with_memory_control_mac
  import conv2_pkg::*;
#(
  parameter int NUM_W   = NUM_W_D,
  parameter int ACC_W   = ACC_W_D,
  parameter int RELU_EN = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [NUM_W-1:0] a,
  input  logic signed [NUM_W-1:0] b,
  input  logic signed [NUM_W-1:0] bias,
  output logic        [NUM_W-1:0] result
);
  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-NUM_W+1){1'b0}}, {(NUM_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {{(ACC_W-NUM_W+1){1'b1}}, {(NUM_W-1){1'b0}}};

  logic signed [2*NUM_W-1:0] prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   prod_x;
  logic signed [ACC_W-1:0]   bias_x;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   shr;

  assign prod   = a * b;
  assign prod_x = {{(ACC_W-2*NUM_W){prod[2*NUM_W-1]}}, prod};
  assign bias_x = {{(ACC_W-NUM_W){bias[NUM_W-1]}}, bias} <<< Q_FRAC;
  assign sum    = acc + bias_x;
  assign shr    = sum >>> Q_FRAC;

  always_comb begin
    result = shr[NUM_W-1:0];
    if (shr > MAXV) begin
      result = MAXV[NUM_W-1:0];
    end else if (shr < MINV) begin
      result = MINV[NUM_W-1:0];
    end
    if (RELU_EN != 0 && result[NUM_W-1]) begin
      result = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_x;
    end
  end
endmodule

// File: rtl/conv2_with_memory_control.sv
// conv2 top: run FSM, tap/pixel counters, BRAM/ROM addressing.
// One 8x8 output channel from a 6x10x10 map.
module conv2_with_memory_control
  import conv2_pkg::*;
#(
  parameter int IN_SIZE    = IN_SIZE_D,
  parameter int OUT_SIZE   = OUT_SIZE_D,
  parameter int CHANNEL    = CHANNEL_D,
  parameter int IN_ADDR_W  = IN_ADDR_W_D,
  parameter int OUT_ADDR_W = OUT_ADDR_W_D,
  parameter int W_ADDR_W   = W_ADDR_W_D,
  parameter int NUM_W      = NUM_W_D,
  parameter int ACC_W      = ACC_W_D,
  parameter int RELU_EN    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_W-1:0]      bias,
  input  logic [NUM_W-1:0]      BRAM_Conv_In,
  output logic [IN_ADDR_W-1:0]  BRAM_Conv_In_Address,
  input  logic [NUM_W-1:0]      weight_data,
  output logic [W_ADDR_W-1:0]   weight_addr,
  output logic                  wr_ena,
  output logic [NUM_W-1:0]      BRAM_Conv_Out,
  output logic [OUT_ADDR_W-1:0] BRAM_Conv_Out_Address,
  output logic                  conv_end
);
  localparam int P_W  = $clog2(OUT_SIZE);
  localparam int CH_W = $clog2(CHANNEL);

  state_t          state, state_n;
  logic            en_q, valid_q;
  logic [1:0]      kr, kc;
  logic [CH_W-1:0] ch;
  logic [P_W-1:0]  r, c;
  logic            last_tap, last_pix;
  logic [NUM_W-1:0]      result;
  logic [IN_ADDR_W-1:0]  in_addr;
  logic [W_ADDR_W-1:0]   w_addr;
  logic [OUT_ADDR_W-1:0] o_addr;

  assign last_tap = (ch == CH_W'(CHANNEL-1)) &&
                    (kr == 2'd2) && (kc == 2'd2);
  assign last_pix = (r == P_W'(OUT_SIZE-1)) &&
                    (c == P_W'(OUT_SIZE-1));

  assign in_addr =
    IN_ADDR_W'(ch) * IN_ADDR_W'(IN_SIZE*IN_SIZE) +
    (IN_ADDR_W'(r) + IN_ADDR_W'(kr)) * IN_ADDR_W'(IN_SIZE) +
    IN_ADDR_W'(c) + IN_ADDR_W'(kc);
  assign w_addr =
    W_ADDR_W'(ch) * W_ADDR_W'(KSIZE*KSIZE) +
    W_ADDR_W'(kr) * W_ADDR_W'(KSIZE) + W_ADDR_W'(kc);
  assign o_addr =
    OUT_ADDR_W'(r) * OUT_ADDR_W'(OUT_SIZE) + OUT_ADDR_W'(c);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (enable && !en_q) state_n = S_MAC;
      S_MAC:   if (last_tap) state_n = S_DRAIN;
      S_DRAIN: state_n = S_WRITE;
      S_WRITE: state_n = last_pix ? S_DONE : S_MAC;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      en_q    <= enable;
      valid_q <= (state == S_MAC);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kc <= '0;
      kr <= '0;
      ch <= '0;
      r  <= '0;
      c  <= '0;
    end else begin
      unique case (state)
        S_MAC: begin
          if (kc == 2'd2) begin
            kc <= '0;
            if (kr == 2'd2) begin
              kr <= '0;
              ch <= last_tap ? '0 : ch + CH_W'(1);
            end else begin
              kr <= kr + 2'd1;
            end
          end else begin
            kc <= kc + 2'd1;
          end
        end
        S_WRITE: begin
          if (c == P_W'(OUT_SIZE-1)) begin
            c <= '0;
            r <= last_pix ? '0 : r + P_W'(1);
          end else begin
            c <= c + P_W'(1);
          end
        end
        S_DRAIN: ;
        default: begin
          kc <= '0;
          kr <= '0;
          ch <= '0;
          r  <= '0;
          c  <= '0;
        end
      endcase
    end
  end

  conv2_with_memory_control_mac #(
    .NUM_W   (NUM_W),
    .ACC_W   (ACC_W),
    .RELU_EN (RELU_EN)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    ((state == S_WRITE) || (state == S_IDLE)),
    .en     (valid_q),
    .a      ($signed(BRAM_Conv_In)),
    .b      ($signed(weight_data)),
    .bias   ($signed(bias)),
    .result (result)
  );

  assign BRAM_Conv_In_Address  = (state == S_MAC) ? in_addr : '0;
  assign weight_addr           = (state == S_MAC) ? w_addr : '0;
  assign wr_ena                = (state == S_WRITE);
  assign BRAM_Conv_Out         = wr_ena ? result : '0;
  assign BRAM_Conv_Out_Address = wr_ena ? o_addr : '0;
  assign conv_end              = (state == S_DONE);
endmodule

// File: tb/tb_conv2_with_memory_control.sv
// Bench for conv2_with_memory_control.
// Two instances: RELU_EN=1 (a) and RELU_EN=0 (b).
module tb_conv2_with_memory_control;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] bias;
  logic [15:0] din_a, din_b, wd_a, wd_b;
  logic [10:0] ia_a, ia_b;
  logic [5:0]  wa_a, wa_b;
  logic        wr_a, wr_b, end_a, end_b;
  logic [15:0] out_a, out_b;
  logic [5:0]  oa_a, oa_b;

  logic [15:0] in_mem [600];
  logic [15:0] w_mem [54];
  logic [15:0] seen_a [64];
  logic [15:0] seen_b [64];

  typedef struct {
    int          addr;
    logic [15:0] da;
    logic [15:0] db;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    din_a <= in_mem[ia_a];
    din_b <= in_mem[ia_b];
    wd_a  <= w_mem[wa_a];
    wd_b  <= w_mem[wa_b];
  end

  conv2_with_memory_control #(.RELU_EN(1)) dut_a (
    .clk(clk), .reset(rst_n), .enable(enable), .bias(bias),
    .BRAM_Conv_In(din_a), .BRAM_Conv_In_Address(ia_a),
    .weight_data(wd_a), .weight_addr(wa_a),
    .wr_ena(wr_a), .BRAM_Conv_Out(out_a),
    .BRAM_Conv_Out_Address(oa_a), .conv_end(end_a)
  );

  conv2_with_memory_control #(.RELU_EN(0)) dut_b (
    .clk(clk), .reset(rst_n), .enable(enable), .bias(bias),
    .BRAM_Conv_In(din_b), .BRAM_Conv_In_Address(ia_b),
    .weight_data(wd_b), .weight_addr(wa_b),
    .wr_ena(wr_b), .BRAM_Conv_Out(out_b),
    .BRAM_Conv_Out_Address(oa_b), .conv_end(end_b)
  );

  function automatic logic [15:0] model(int p, bit relu);
    longint acc = 0;
    int r = p / 8;
    int c = p % 8;
    for (int ch = 0; ch < 6; ch++)
      for (int kr = 0; kr < 3; kr++)
        for (int kc = 0; kc < 3; kc++)
          acc += longint'($signed(in_mem[ch*100 + (r+kr)*10 + c+kc]))
               * longint'($signed(w_mem[ch*9 + kr*3 + kc]));
    acc += longint'($signed(bias)) * 256;
    acc = acc >>> 8;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return 16'(acc);
  endfunction

  function automatic logic [63:0] outs();
    return {wr_a, end_a, out_a, oa_a, ia_a, wa_a,
            wr_b, end_b, out_b, oa_b};
  endfunction

  // mode 0: drop enable early, 1: hold high, 2: toggle through the run
  task automatic run_check(input string nm, input int mode,
                           input bit chk_addr);
    int k, p, j, nw, ch, kr, kc;
    int exp_ia;
    bit done;
    exp_t e;
    sb.delete();
    for (int q = 0; q < 64; q++)
      sb.push_back('{q, model(q, 1), model(q, 0), 56*q + 55});
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    done = 1'b0;
    nw = 0;
    for (k = 0; k < 4000 && !done; k++) begin
      @(negedge clk);
      if (mode == 0 && k == 2) enable = 1'b0;
      if (mode == 2) enable = ((k / 17) % 2) == 0;
      if (chk_addr && k < 3584 && (k % 56) < 54) begin
        j = k % 56;
        p = k / 56;
        ch = j / 9;
        kr = (j % 9) / 3;
        kc = j % 3;
        exp_ia = ch*100 + (p/8 + kr)*10 + p%8 + kc;
        n_cmp++;
        if (ia_a !== 11'(exp_ia)) begin
          n_bad++;
          $display("FAIL %s in_addr cyc %0d got %0d want %0d",
                   nm, k, ia_a, exp_ia);
        end
        n_cmp++;
        if (wa_a !== 6'(j)) begin
          n_bad++;
          $display("FAIL %s w_addr cyc %0d got %0d want %0d",
                   nm, k, wa_a, j);
        end
      end
      if (wr_a) begin
        nw++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL %s extra write cyc %0d got %0d want 64",
                   nm, k, nw);
        end else begin
          e = sb.pop_front();
          if (oa_a !== 6'(e.addr) || k != e.cyc) begin
            n_bad++;
            $display("FAIL %s wr addr/cyc got %0d/%0d want %0d/%0d",
                     nm, oa_a, k, e.addr, e.cyc);
          end
          n_cmp++;
          if (out_a !== e.da) begin
            n_bad++;
            $display("FAIL %s data_a px %0d got %h want %h",
                     nm, e.addr, out_a, e.da);
          end
          n_cmp++;
          if (wr_b !== 1'b1 || out_b !== e.db) begin
            n_bad++;
            $display("FAIL %s data_b px %0d got %b/%h want 1/%h",
                     nm, e.addr, wr_b, out_b, e.db);
          end
          seen_a[e.addr] = out_a;
          seen_b[e.addr] = out_b;
        end
      end
      if (end_a) begin
        done = 1'b1;
        n_cmp++;
        if (k != 3584 || nw != 64) begin
          n_bad++;
          $display("FAIL %s conv_end cyc/writes got %0d/%0d want 3584/64",
                   nm, k, nw);
        end
      end
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s timeout got no conv_end want conv_end", nm);
    end
    sb.delete();
  endtask

  task automatic test_reset();
    enable = 1'b0;
    bias = 16'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (outs() !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_outs got %h want 0", outs());
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (outs() !== 64'h0) begin
      n_bad++;
      $display("FAIL idle_outs got %h want 0", outs());
    end
  endtask

  task automatic test_zero_bias();
    for (int i = 0; i < 600; i++) in_mem[i] = 16'h0;
    for (int i = 0; i < 54; i++) w_mem[i] = 16'($urandom);
    bias = 16'h0100;
    run_check("zero_bias", 0, 0);
    n_cmp++;
    if (seen_a[0] !== 16'h0100 || seen_a[63] !== 16'h0100) begin
      n_bad++;
      $display("FAIL zero_bias const got %h/%h want 0100",
               seen_a[0], seen_a[63]);
    end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 600; i++) in_mem[i] = 16'(i);
    for (int i = 0; i < 54; i++) w_mem[i] = 16'h0;
    w_mem[4] = 16'h0100;
    bias = 16'h0;
    run_check("ramp", 0, 1);
    n_cmp++;
    if (seen_a[0] !== 16'h000B || seen_a[63] !== 16'h0058 ||
        seen_a[9] !== 16'h0016) begin
      n_bad++;
      $display("FAIL ramp const got %h/%h/%h want 000b/0058/0016",
               seen_a[0], seen_a[63], seen_a[9]);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 600; i++) in_mem[i] = 16'h7FFF;
    for (int i = 0; i < 54; i++) w_mem[i] = 16'h7FFF;
    bias = 16'h0;
    run_check("sat_pos", 0, 0);
    n_cmp++;
    if (seen_a[5] !== 16'h7FFF || seen_b[40] !== 16'h7FFF) begin
      n_bad++;
      $display("FAIL sat_pos got %h/%h want 7fff",
               seen_a[5], seen_b[40]);
    end
    for (int i = 0; i < 54; i++) w_mem[i] = 16'h8001;
    run_check("sat_neg", 0, 0);
    n_cmp++;
    if (seen_a[5] !== 16'h0000 || seen_b[5] !== 16'h8000) begin
      n_bad++;
      $display("FAIL sat_neg got %h/%h want 0000/8000",
               seen_a[5], seen_b[5]);
    end
  endtask

  task automatic load_random();
    logic [9:0]  t;
    logic [7:0]  u;
    logic [11:0] bb;
    for (int i = 0; i < 600; i++) begin
      t = 10'($urandom);
      in_mem[i] = {{6{t[9]}}, t};
    end
    for (int i = 0; i < 54; i++) begin
      u = 8'($urandom);
      w_mem[i] = {{8{u[7]}}, u};
    end
    bb = 12'($urandom);
    bias = {{4{bb[11]}}, bb};
  endtask

  task automatic test_random();
    load_random();
    run_check("random", 0, 0);
  endtask

  task automatic test_toggle_enable();
    load_random();
    run_check("toggle", 2, 1);
    enable = 1'b0;
  endtask

  task automatic test_hold_enable();
    int nw = 0;
    load_random();
    run_check("hold", 1, 0);
    repeat (200) begin
      @(negedge clk);
      if (wr_a || ia_a != 11'd0) nw++;
    end
    n_cmp++;
    if (nw != 0) begin
      n_bad++;
      $display("FAIL hold_no_rerun got %0d active cycles want 0", nw);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    int nw = 0;
    for (int i = 0; i < 600; i++) in_mem[i] = 16'(i);
    for (int i = 0; i < 54; i++) w_mem[i] = 16'(i + 1);
    bias = 16'h0040;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (56*20 + 10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_mid_outs got %h want 0", outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (wr_a || wr_b || end_a) nw++;
    end
    n_cmp++;
    if (nw != 0) begin
      n_bad++;
      $display("FAIL reset_mid_writes got %0d want 0", nw);
    end
    run_check("restart", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    bias = 16'h0;
    test_reset();
    test_zero_bias();
    test_ramp();
    test_saturate();
    test_random();
    test_toggle_enable();
    test_hold_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
